// File: rtl/dkong_scandoubler.sv
// dkong_scandoubler
//   Line-doubling scan converter for the Donkey Kong video pipeline. Each
//   active arcade line (up to 256 pixels, 8-bit RGB 3:3:2) is captured into
//   one half of a ping-pong line buffer. Meanwhile the other half is replayed
//   twice at double line rate with locally generated hsync, vsync and data
//   enable. The output line counter is re-phased to every arcade line start,
//   so the two replays fill exactly one arcade line period.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   htiming[9:0]        arcade horizontal counter 0..767 (line start = 767->0)
//   vblk                arcade vertical blank (rising edge arms vsync)
//   video_valid         one-clk strobe per active input pixel
//   r_in/g_in/b_in      pixel colour, qualified by video_valid
//   vga_r/vga_g/vga_b   output colour, forced to 0 outside the active span
//   vga_de              output pixel active
//   vga_hs, vga_vs      syncs, active level set by HS_POL / VS_POL
//
// All outputs leave through the same 2-stage read pipeline (decode ->
// RAM address -> data/DE), so colour, DE and both syncs stay aligned.

// One line buffer bank. It has a single write port and a single registered
// read port. The read register clears when the port is not enabled. Because
// of that, the top can OR the bank outputs together instead of muxing them.
module dkong_linebuf #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !re) rd_data <= '0;
    else               rd_data <= mem[rd_addr];
  end
endmodule

module dkong_scandoubler #(
  parameter int OUT_HTOTAL = 1920,
  parameter int PIX_DIV    = 4,
  parameter int OUT_HSTART = 320,
  parameter int HS_START   = 32,
  parameter int HS_LEN     = 224,
  parameter int VS_LINES   = 2,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] htiming,
  input  logic       vblk,
  input  logic       video_valid,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [1:0] b_in,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_de,
  output logic       vga_hs,
  output logic       vga_vs
);
  localparam int NUM_BANKS = 2;
  localparam int LINE_W    = 256;
  localparam int AW        = $clog2(LINE_W);
  localparam int XW        = $clog2(OUT_HTOTAL);
  localparam int LCW       = $clog2(VS_LINES + 1);
  localparam int STAGES    = 2;

  // Horizontal decode points, sized to out_x.
  localparam logic [XW-1:0] X_LAST = XW'(OUT_HTOTAL - 1);
  localparam logic [XW-1:0] X_ACT0 = XW'(OUT_HSTART);
  localparam logic [XW-1:0] X_ACT1 = XW'(OUT_HSTART + LINE_W * PIX_DIV);
  localparam logic [XW-1:0] X_HS0  = XW'(HS_START);
  localparam logic [XW-1:0] X_HS1  = XW'(HS_START + HS_LEN);
  localparam logic [XW-1:0] X_PDIV = XW'(PIX_DIV);
  localparam logic [LCW-1:0] VS_LAST = LCW'(VS_LINES - 1);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } ctl_t;

  typedef enum logic [1:0] {VS_IDLE, VS_ARMED, VS_PULSE} vs_state_t;

  // ---------------------------------------------------------------- line start
  logic [9:0] ht_d;
  logic       ls;
  logic       vblk_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ht_d   <= '0;
      ls     <= 1'b0;
      vblk_d <= 1'b0;
    end else begin
      ht_d   <= htiming;
      ls     <= (ht_d == 10'd767) && (htiming == 10'd0);
      vblk_d <= vblk;
    end
  end

  // ---------------------------------------------------------------- write side
  // A strobe that coincides with ls already belongs to the new line. The bank
  // select and the address are therefore resolved as if the swap had happened.
  logic                               wr_bank;
  logic [AW:0]                        wr_x;
  logic [NUM_BANKS-1:0][AW:0]         cnt;
  logic                               wr_sel;
  logic [AW:0]                        wr_base;
  logic                               wr_ok;
  logic                               rd_bank;

  always_comb begin
    wr_sel  = ls ? ~wr_bank : wr_bank;
    wr_base = ls ? '0 : wr_x;
    // The MSB of wr_base marks a full line; extra strobes are dropped.
    wr_ok   = rst_n && video_valid && !wr_base[AW];
    rd_bank = ~wr_bank;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_x    <= '0;
      cnt     <= '0;
    end else begin
      if (ls) begin
        wr_bank      <= ~wr_bank;
        cnt[wr_bank] <= wr_x;
      end
      wr_x <= wr_base + {{AW{1'b0}}, wr_ok};
    end
  end

  // ---------------------------------------------------------------- read timing
  // out_x runs freely at OUT_HTOTAL. Each arcade line start re-phases it, so
  // when ls stops the last captured line keeps repeating.
  logic [XW-1:0] out_x;

  always_ff @(posedge clk) begin
    if (!rst_n)               out_x <= '0;
    else if (ls)              out_x <= '0;
    else if (out_x == X_LAST) out_x <= '0;
    else                      out_x <= out_x + XW'(1);
  end

  // Decode stage (pipeline stage 0).
  logic          in_act;
  logic [XW-1:0] rel;
  logic [XW-1:0] pix;
  logic          de_c;
  logic          hs_c;
  logic          vs_c;

  always_comb begin
    in_act = (out_x >= X_ACT0) && (out_x < X_ACT1);
    rel    = out_x - X_ACT0;
    pix    = rel / X_PDIV;
    de_c   = in_act && (pix < XW'(cnt[rd_bank]));
    hs_c   = (out_x >= X_HS0) && (out_x < X_HS1);
  end

  // ---------------------------------------------------------------- vsync FSM
  // A vblk rising edge arms the pulse. The pulse opens at the next output line
  // start and stays up for VS_LINES output line starts. A rising edge seen
  // while armed or pulsing is ignored. vs_c is decoded against the same out_x
  // as hs/de, so vsync edges land exactly on out_x == 0.
  vs_state_t      vs_state, vs_next;
  logic [LCW-1:0] lcnt, lcnt_next;
  logic           line0;
  logic           vblk_rise;

  always_comb begin
    line0     = (out_x == '0);
    vblk_rise = vblk && !vblk_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_state <= VS_IDLE;
      lcnt     <= '0;
    end else begin
      vs_state <= vs_next;
      lcnt     <= lcnt_next;
    end
  end

  always_comb begin
    vs_next   = vs_state;
    lcnt_next = lcnt;
    vs_c      = 1'b0;
    unique case (vs_state)
      VS_IDLE: begin
        if (vblk_rise) vs_next = VS_ARMED;
      end
      VS_ARMED: begin
        if (line0) begin
          vs_next   = VS_PULSE;
          lcnt_next = '0;
          vs_c      = 1'b1;
        end
      end
      VS_PULSE: begin
        vs_c = 1'b1;
        if (line0) begin
          if (lcnt == VS_LAST) begin
            vs_next = VS_IDLE;
            vs_c    = 1'b0;
          end else begin
            lcnt_next = lcnt + LCW'(1);
          end
        end
      end
      default: vs_next = VS_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- pipeline
  // Stage 1 holds the RAM address/bank. Stage 2 is the RAM output register
  // (inside the banks) plus the aligned control bits.
  ctl_t [STAGES:1] ctl_pipe;
  logic [AW-1:0]   rd_addr;
  logic            rd_bank_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_pipe  <= '0;
      rd_addr   <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      ctl_pipe[1] <= '{de: de_c, hs: hs_c, vs: vs_c};
      for (int s = 2; s <= STAGES; s++) ctl_pipe[s] <= ctl_pipe[s-1];
      rd_addr   <= pix[AW-1:0];
      rd_bank_q <= rd_bank;
    end
  end

  logic [NUM_BANKS-1:0][7:0] bank_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dkong_linebuf #(.AW(AW), .DW(8)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_ok && (wr_sel == 1'(b))),
      .wr_addr (wr_base[AW-1:0]),
      .wr_data ({r_in, g_in, b_in}),
      .re      (ctl_pipe[1].de && (rd_bank_q == 1'(b))),
      .rd_addr (rd_addr),
      .rd_data (bank_q[b])
    );
  end

  // At most one bank read register is non-zero, so OR-merge is a bank mux.
  logic [7:0] pix_q;

  always_comb begin
    pix_q = '0;
    for (int b = 0; b < NUM_BANKS; b++) pix_q = pix_q | bank_q[b];
  end

  assign {vga_r, vga_g, vga_b} = pix_q;
  assign vga_de = ctl_pipe[STAGES].de;
  assign vga_hs = ctl_pipe[STAGES].hs ? HS_POL : ~HS_POL;
  assign vga_vs = ctl_pipe[STAGES].vs ? VS_POL : ~VS_POL;
endmodule

// File: tb/tb_dkong_scandoubler.sv
// Self-checking bench for dkong_scandoubler. Random arcade lines are driven
// in. A line-level reference model (captured lines kept as arrays, output
// position counted from the last line start) predicts every output cycle.
module tb_dkong_scandoubler;
  localparam int  HTOT   = 1920;
  localparam int  PDIV   = 4;
  localparam int  HSTART = 320;
  localparam int  HS0    = 32;
  localparam int  HS1    = 32 + 224;
  localparam int  VSL    = 2;
  localparam bit  HS_POL = 1'b0;
  localparam bit  VS_POL = 1'b0;
  localparam int  ALINE  = 3840;  // clk per arcade line

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] htiming;
  logic       vblk;
  logic       video_valid;
  logic [2:0] r_in, g_in;
  logic [1:0] b_in;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;
  logic       vga_de, vga_hs, vga_vs;

  always #5 clk = ~clk;

  dkong_scandoubler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .htiming     (htiming),
    .vblk        (vblk),
    .video_valid (video_valid),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_de      (vga_de),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } exp_t;

  exp_t       exp_d1, exp_d2;
  logic [7:0] m_cur   [256];
  logic [7:0] m_shown [256];
  int         m_cur_n, m_shown_n;
  int         m_x;           // output position within the current output line
  bit         m_ls;          // arcade line start seen, takes effect next edge
  logic [9:0] m_ht_prev;
  bit         m_vblk_prev;
  bit         m_armed;
  int         m_vs_left;     // output lines of vsync still to show

  always @(posedge clk) begin : model
    exp_t e;
    bit   busy;
    int   p;
    if (!rst_n) begin
      m_x = 0; m_cur_n = 0; m_shown_n = 0; m_ls = 0; m_ht_prev = '0;
      m_vblk_prev = 0; m_armed = 0; m_vs_left = 0;
      exp_d1 = '0; exp_d2 = '0;
    end else begin
      // What this cycle's position shows, visible two clocks later.
      busy = m_armed || (m_vs_left > 0);
      if (m_x == 0) begin
        if (m_armed) begin
          m_armed = 0;
          m_vs_left = VSL;
        end else if (m_vs_left > 0) begin
          m_vs_left--;
        end
      end
      e.vs  = (m_vs_left > 0);
      e.hs  = (m_x >= HS0) && (m_x < HS1);
      e.de  = 1'b0;
      e.rgb = 8'h00;
      if (m_x >= HSTART && m_x < HSTART + 256 * PDIV) begin
        p = (m_x - HSTART) / PDIV;
        if (p < m_shown_n) begin
          e.de  = 1'b1;
          e.rgb = m_shown[p];
        end
      end
      exp_d2 = exp_d1;
      exp_d1 = e;
      // Line bookkeeping.
      if (m_ls) begin
        m_shown   = m_cur;
        m_shown_n = m_cur_n;
        m_cur_n   = 0;
        m_x       = 0;
      end else begin
        m_x = (m_x + 1) % HTOT;
      end
      if (video_valid && m_cur_n < 256) begin
        m_cur[m_cur_n] = {r_in, g_in, b_in};
        m_cur_n++;
      end
      m_ls      = (m_ht_prev == 10'd767) && (htiming == 10'd0);
      m_ht_prev = htiming;
      if (vblk && !m_vblk_prev && !busy) m_armed = 1;
      m_vblk_prev = vblk;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("de",  32'(vga_de), 32'(exp_d2.de));
      chk("hs",  32'(vga_hs), 32'(exp_d2.hs ? HS_POL : !HS_POL));
      chk("vs",  32'(vga_vs), 32'(exp_d2.vs ? VS_POL : !VS_POL));
      chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_d2.rgb));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arcade line. n strobes spaced by a random step; coll puts 0xAA on the
  // strobe that coincides with the line-start pulse. vr/vf: vblk rise/fall
  // cycle, rst_at: start of a 10-clk reset (-1 = none).
  task automatic run_line(input int n, input bit ramp, input bit coll,
                          input int vr, input int vf, input int rst_at);
    int step, nxt, k;
    step = $urandom_range(2, 12);
    if (n > 0 && n * step > 3700) step = 3700 / n;
    k   = 0;
    nxt = 10;
    for (int i = 0; i < ALINE; i++) begin
      htiming     = 10'(i / 5);
      video_valid = 1'b0;
      {r_in, g_in, b_in} = 8'($urandom);
      if (coll && i == 1) begin
        video_valid = 1'b1;
        {r_in, g_in, b_in} = 8'hAA;
      end else if (i == nxt && k < n) begin
        video_valid = 1'b1;
        {r_in, g_in, b_in} = ramp ? 8'(k) : 8'($urandom);
        k++;
        nxt += step;
      end
      if (i == vr) vblk = 1'b1;
      if (i == vf) vblk = 1'b0;
      rst_n = !(rst_at >= 0 && i >= rst_at && i < rst_at + 10);
      tick();
    end
  endtask

  // No arcade line starts: output keeps wrapping on its own.
  task automatic free_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      htiming     = (i == cycles - 1) ? 10'd767 : 10'd300;
      video_valid = 1'b0;
      {r_in, g_in, b_in} = 8'($urandom);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; htiming = '0; vblk = 1'b0; video_valid = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    tick();
    chk_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      htiming     = 10'($urandom_range(0, 767));
      vblk        = 1'($urandom);
      video_valid = 1'($urandom);
      {r_in, g_in, b_in} = 8'($urandom);
      tick();
    end
    htiming = '0; vblk = 1'b0; video_valid = 1'b0;

    run_line(256, 1, 0,  -1,   -1, -1);  // ramp
    run_line(256, 0, 0,  -1,   -1, -1);
    run_line(100, 0, 0,  -1,   -1, -1);  // short line
    run_line(300, 0, 0,  -1,   -1, -1);  // overlong line
    run_line(60,  0, 1, 500, 3000, -1);  // ls collision, vblk rise mid-line
    run_line(256, 0, 0, 500,   -1, -1);  // second vblk rise during pulse
    run_line(200, 0, 0,  -1,  100, -1);
    free_run(3 * HTOT + 700);
    run_line(150, 0, 0,  -1,   -1, -1);
    run_line(256, 0, 0,  -1,   -1, 1500); // reset mid-frame
    run_line(256, 0, 0,  -1,   -1, -1);
    run_line(80,  0, 0,  -1,   -1, -1);
    run_line(0,   0, 0,  -1,   -1, -1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dkong_scandoubler.md
# dkong_scandoubler

Line-doubling scan converter downstream of the Donkey Kong video pipeline. Captures each active 256-pixel arcade line (8-bit RGB, `video_valid` strobed) into a ping-pong line buffer and replays the previous line twice at double line rate with its own VGA-style sync and data-enable, phase-locked to the arcade horizontal counter. Output feeds the board's VGA DAC/encoder.

## Interface

Parameters:
- `OUT_HTOTAL`, 1920: clk cycles per output line; must equal half the arcade line (768 htiming counts × 5 clk / 2).
- `PIX_DIV`, 4: clk cycles each output pixel is held.
- `OUT_HSTART`, 320: out_x of first active pixel.
- `HS_START`, 32 / `HS_LEN`, 224: hsync pulse start and width in clk.
- `VS_LINES`, 2: vsync width in output lines.
- `HS_POL`, 0 / `VS_POL`, 0: active level of syncs.

Ports:
- `clk` in 1: system clock (61.44 MHz domain).
- `rst_n` in 1: reset, synchronous, active-low; clock clk.
- `htiming` in 10: arcade horizontal counter, 0..767.
- `vblk` in 1: arcade vertical blank.
- `video_valid` in 1: one-clk strobe per active input pixel.
- `r_in` in 3, `g_in` in 3, `b_in` in 2: pixel colour, valid with strobe.
- `vga_r` out 3, `vga_g` out 3, `vga_b` out 2: output colour.
- `vga_de` out 1: output pixel active.
- `vga_hs` out 1, `vga_vs` out 1: syncs.

## Operation

- Line start (`ls`): registered pulse, one clk, when htiming_d == 767 and htiming == 0.
- Write side: two 256×8 banks. On `ls`: `wr_bank` toggles, `cnt[wr_bank_old]` ← `wr_x`, `wr_x` ← 0. On `video_valid` with `wr_x` < 256: write {r,g,b} at `wr_x`, increment. Strobes at `wr_x` = 256 are ignored (saturate at 256, 9-bit counter).
- Simultaneous `ls` and `video_valid`: the pixel belongs to the new line (written at address 0 of the new bank, `wr_x` → 1).
- Read side: `rd_bank` = ~`wr_bank`. `out_x` counts 0..OUT_HTOTAL-1; on `ls` forced to 0 and `half` ← 0; on natural wrap `half` ← 1 (further wraps without `ls` keep free-running, `half` stays 1).
- Pixel index p = (out_x − OUT_HSTART) / PIX_DIV when OUT_HSTART ≤ out_x < OUT_HSTART + 256·PIX_DIV. DE requires p < `cnt[rd_bank]`; otherwise colour forced to 0.
- hsync asserted while HS_START ≤ out_x < HS_START+HS_LEN.
- Vsync FSM: IDLE → (vblk rising edge) ARMED → (next output line start, out_x = 0) PULSE, line counter = 0 → after VS_LINES output line starts → IDLE. vblk rising while in PULSE is ignored.
- Reset mid-frame: all counters, banks select, `cnt` = 0, FSM IDLE; first full output line appears after the second `ls`.

## Timing

- Reset values: `vga_r/g/b` = 0, `vga_de` = 0, `vga_hs` = ~HS_POL, `vga_vs` = ~VS_POL, `wr_bank` = 0, `out_x` = 0, `half` = 0, `cnt[*]` = 0.
- Read pipeline 2 clk: cycle n decode out_x → cycle n+1 RAM address registered → cycle n+2 data/DE registered on outputs. hs and vs delayed identically, so all outputs align.
- Write-to-read latency: a line is visible starting the output line following its closing `ls`, shown in two consecutive output lines (half 0, half 1).
- Each output pixel stable exactly PIX_DIV clk; 256 pixels span 1024 clk.
- RAM: single write port, single registered read port per bank; no read/write collision since banks differ.

## Test plan

- Reset: hold rst_n low 10 clk with random inputs → vga_de=0, colour 0, hs=vs=1 (POL=0), no output change for first OUT_HTOTAL after release until second `ls`.
- Ramp line: 256 strobes with colour = x[7:0], then `ls` → next two output lines show 256 pixels, values 0..255, each held 4 clk, de high 1024 clk starting out_x=OUT_HSTART+2 pipeline offset.
- Short line: 100 strobes then `ls` → de high only 400 clk per output line, colour 0 elsewhere; 300 strobes → only first 256 stored, de 1024 clk.
- Ls collision: strobe coincident with `ls` value 0xAA → appears as pixel 0 of following line.
- Vsync: vblk rises mid-line → vs low for exactly 2 output lines beginning at next out_x=0 (+2 clk); second vblk edge during pulse has no effect.
- Free-run: stop `ls` for 3 output periods → out_x wraps every 1920 clk, hs period 1920, last line repeated, no X on outputs.
